prim_assembly_rx: RTL and testbench

//  Consumer end of the vertex-transform -> primitive-assembly FIFO.
//  - Collects 12 words per triangle: 3 vertices x {X,Y,Z,W}, already in screen-space integers.
//  - Computes edge deltas, signed doubled area and a viewport-clamped bounding box.
//  - Culls degenerate, back-facing and fully off-screen triangles.
//  - Presents surviving triangles to the rasterizer over a valid/ready handshake.

---
 rtl/prim_assembly_rx.sv | 245 ++++++++++++++++++++++++
 tb/tb_prim_assembly_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_assembly_rx.sv
// Purpose: collects 12-word triangles from the vertex FIFO, computes area and bbox, culls, and hands surviving triangles to the rasterizer.
// Latency: tri_valid rises 4 cycles after the edge that accepts word 11; at most one triangle every 17 cycles.
// Backpressure: FIFO ready is low outside COLLECT; tri_* and bbox_* hold while tri_valid && !tri_ready.
module prim_assembly_rx #(
  parameter int SCREEN_W  = 800,
  parameter int SCREEN_H  = 600,
  parameter int COORD_W   = 16,
  parameter bit CULL_BACK = 1'b1
) (
  input  logic                   pll_clock,
  input  logic                   sys_reset,
  input  logic                   prim_assembly_fifo_out_valid,
  input  logic [31:0]            prim_assembly_fifo_out_data,
  output logic                   prim_assembly_fifo_out_ready,
  output logic                   tri_valid,
  input  logic                   tri_ready,
  output logic [3*COORD_W-1:0]   tri_x,
  output logic [3*COORD_W-1:0]   tri_y,
  output logic [95:0]            tri_z,
  output logic [2*COORD_W+2:0]   tri_area,
  output logic [COORD_W-1:0]     bbox_xmin,
  output logic [COORD_W-1:0]     bbox_xmax,
  output logic [COORD_W-1:0]     bbox_ymin,
  output logic [COORD_W-1:0]     bbox_ymax,
  output logic [15:0]            culled_count
);

  // Delta width holds the difference of two COORD_W values; the products and
  // their difference grow from there.
  localparam int DW = COORD_W + 1;
  localparam int PW = 2 * DW;
  localparam int AW = 2 * COORD_W + 3;

  localparam logic signed [31:0]        SAT_HI = 32'((1 << (COORD_W - 1)) - 1);
  localparam logic signed [31:0]        SAT_LO = 32'(-(1 << (COORD_W - 1)));
  localparam logic signed [COORD_W-1:0] XLIM   = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] YLIM   = COORD_W'(SCREEN_H - 1);
  localparam logic signed [COORD_W-1:0] CZERO  = '0;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_DIFF,
    ST_MUL,
    ST_AREA,
    ST_DECIDE,
    ST_OUT
  } state_e;

  state_e state_q, state_d;
  logic [3:0]  widx_q, widx_d;
  logic        rdy_q, rdy_d;
  logic        tvld_q, tvld_d;
  logic [15:0] culled_q, culled_d;

  logic signed [COORD_W-1:0] x_q [3];
  logic signed [COORD_W-1:0] y_q [3];
  logic [31:0]               z_q [3];

  logic signed [DW-1:0]      dx1_q, dy1_q, dx2_q, dy2_q;
  logic signed [COORD_W-1:0] xmin_raw_q, xmax_raw_q, ymin_raw_q, ymax_raw_q;
  logic signed [PW-1:0]      p1_q, p2_q;
  logic signed [AW-1:0]      area_q;
  logic [COORD_W-1:0]        bxmin_q, bxmax_q, bymin_q, bymax_q;

  logic       take;
  logic [1:0] vtx;
  logic [1:0] comp;
  logic       cull;

  function automatic logic signed [COORD_W-1:0] sat_coord(input logic signed [31:0] v);
    if (v > SAT_HI)      return SAT_HI[COORD_W-1:0];
    else if (v < SAT_LO) return SAT_LO[COORD_W-1:0];
    else                 return v[COORD_W-1:0];
  endfunction

  function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a,
                                                     input logic signed [COORD_W-1:0] b,
                                                     input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a,
                                                     input logic signed [COORD_W-1:0] b,
                                                     input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic signed [DW-1:0] sub_ext(input logic signed [COORD_W-1:0] a,
                                                   input logic signed [COORD_W-1:0] b);
    return $signed({a[COORD_W-1], a}) - $signed({b[COORD_W-1], b});
  endfunction

  function automatic logic signed [PW-1:0] mul_ext(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    return $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
  endfunction

  assign take = prim_assembly_fifo_out_valid && rdy_q;
  assign vtx  = widx_q[3:2];
  assign comp = widx_q[1:0];

  // Zero area, optional back-face, or a raw bbox entirely outside the viewport.
  assign cull = (area_q == '0)
             || (CULL_BACK && area_q[AW-1])
             || (xmax_raw_q < CZERO) || (xmin_raw_q > XLIM)
             || (ymax_raw_q < CZERO) || (ymin_raw_q > YLIM);

  // Control state register; reset discards any partial triangle.
  always_ff @(posedge pll_clock) begin
    if (sys_reset) begin
      state_q  <= ST_COLLECT;
      widx_q   <= 4'd0;
      rdy_q    <= 1'b1;
      tvld_q   <= 1'b0;
      culled_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      rdy_q    <= rdy_d;
      tvld_q   <= tvld_d;
      culled_q <= culled_d;
    end
  end

  // Next-state, word index, handshake flags and cull counter.
  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    rdy_d    = rdy_q;
    tvld_d   = tvld_q;
    culled_d = culled_q;
    case (state_q)
      ST_COLLECT: begin
        if (take) begin
          if (widx_q == 4'd11) begin
            widx_d  = 4'd0;
            rdy_d   = 1'b0;
            state_d = ST_DIFF;
          end else begin
            widx_d = widx_q + 4'd1;
          end
        end
      end
      ST_DIFF:   state_d = ST_MUL;
      ST_MUL:    state_d = ST_AREA;
      ST_AREA:   state_d = ST_DECIDE;
      ST_DECIDE: begin
        if (cull) begin
          if (culled_q != 16'hFFFF) culled_d = culled_q + 16'd1;
          rdy_d   = 1'b1;
          state_d = ST_COLLECT;
        end else begin
          tvld_d  = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (tvld_q && tri_ready) begin
          tvld_d  = 1'b0;
          rdy_d   = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        widx_d  = 4'd0;
        rdy_d   = 1'b1;
        tvld_d  = 1'b0;
      end
    endcase
  end

  // Datapath pipeline: capture words, then one arithmetic step per state.
  always_ff @(posedge pll_clock) begin
    if (sys_reset) begin
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
      dx1_q      <= '0;
      dy1_q      <= '0;
      dx2_q      <= '0;
      dy2_q      <= '0;
      xmin_raw_q <= '0;
      xmax_raw_q <= '0;
      ymin_raw_q <= '0;
      ymax_raw_q <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      area_q     <= '0;
      bxmin_q    <= '0;
      bxmax_q    <= '0;
      bymin_q    <= '0;
      bymax_q    <= '0;
    end else begin
      if (state_q == ST_COLLECT && take) begin
        case (comp)
          2'd0:    x_q[vtx] <= sat_coord(prim_assembly_fifo_out_data);
          2'd1:    y_q[vtx] <= sat_coord(prim_assembly_fifo_out_data);
          2'd2:    z_q[vtx] <= prim_assembly_fifo_out_data;
          default: ;  // W is not needed downstream
        endcase
      end
      if (state_q == ST_DIFF) begin
        dx1_q      <= sub_ext(x_q[1], x_q[0]);
        dy1_q      <= sub_ext(y_q[1], y_q[0]);
        dx2_q      <= sub_ext(x_q[2], x_q[0]);
        dy2_q      <= sub_ext(y_q[2], y_q[0]);
        xmin_raw_q <= min3(x_q[0], x_q[1], x_q[2]);
        xmax_raw_q <= max3(x_q[0], x_q[1], x_q[2]);
        ymin_raw_q <= min3(y_q[0], y_q[1], y_q[2]);
        ymax_raw_q <= max3(y_q[0], y_q[1], y_q[2]);
      end
      if (state_q == ST_MUL) begin
        p1_q <= mul_ext(dx1_q, dy2_q);
        p2_q <= mul_ext(dx2_q, dy1_q);
      end
      if (state_q == ST_AREA) begin
        area_q  <= $signed({p1_q[PW-1], p1_q}) - $signed({p2_q[PW-1], p2_q});
        bxmin_q <= (xmin_raw_q < CZERO) ? CZERO : xmin_raw_q;
        bxmax_q <= (xmax_raw_q > XLIM)  ? XLIM  : xmax_raw_q;
        bymin_q <= (ymin_raw_q < CZERO) ? CZERO : ymin_raw_q;
        bymax_q <= (ymax_raw_q > YLIM)  ? YLIM  : ymax_raw_q;
      end
    end
  end

  assign prim_assembly_fifo_out_ready = rdy_q;
  assign tri_valid    = tvld_q;
  assign tri_x        = {x_q[2], x_q[1], x_q[0]};
  assign tri_y        = {y_q[2], y_q[1], y_q[0]};
  assign tri_z        = {z_q[2], z_q[1], z_q[0]};
  assign tri_area     = area_q;
  assign bbox_xmin    = bxmin_q;
  assign bbox_xmax    = bxmax_q;
  assign bbox_ymin    = bymin_q;
  assign bbox_ymax    = bymax_q;
  assign culled_count = culled_q;

endmodule

// File: tb/tb_prim_assembly_rx.sv
// Purpose: directed table-driven bench for prim_assembly_rx plus multi-cycle corner sequences.
// Latency: expects tri_valid 4 cycles after word 11 and ready the cycle after a cull.
// Backpressure: exercises tri_ready stalls, mid-triangle reset and reset during handshake.
module tb_prim_assembly_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        fvld;
  logic        sel;
  logic        tri_ready;
  logic [31:0] fdat;

  always #5 clk = ~clk;

  logic        fvld_a, fvld_b;
  logic        rdy_a, rdy_b, tv_a, tv_b;
  logic [47:0] tx_a, tx_b, ty_a, ty_b;
  logic [95:0] tz_a, tz_b;
  logic [34:0] ar_a, ar_b;
  logic [15:0] bx0_a, bx1_a, by0_a, by1_a, cc_a;
  logic [15:0] bx0_b, bx1_b, by0_b, by1_b, cc_b;

  assign fvld_a = fvld & ~sel;
  assign fvld_b = fvld & sel;

  prim_assembly_rx u_dut (
    .pll_clock(clk), .sys_reset(rst),
    .prim_assembly_fifo_out_valid(fvld_a), .prim_assembly_fifo_out_data(fdat),
    .prim_assembly_fifo_out_ready(rdy_a), .tri_valid(tv_a), .tri_ready(tri_ready),
    .tri_x(tx_a), .tri_y(ty_a), .tri_z(tz_a), .tri_area(ar_a),
    .bbox_xmin(bx0_a), .bbox_xmax(bx1_a), .bbox_ymin(by0_a), .bbox_ymax(by1_a),
    .culled_count(cc_a)
  );

  prim_assembly_rx #(.CULL_BACK(1'b0)) u_dut_nb (
    .pll_clock(clk), .sys_reset(rst),
    .prim_assembly_fifo_out_valid(fvld_b), .prim_assembly_fifo_out_data(fdat),
    .prim_assembly_fifo_out_ready(rdy_b), .tri_valid(tv_b), .tri_ready(tri_ready),
    .tri_x(tx_b), .tri_y(ty_b), .tri_z(tz_b), .tri_area(ar_b),
    .bbox_xmin(bx0_b), .bbox_xmax(bx1_b), .bbox_ymin(by0_b), .bbox_ymax(by1_b),
    .culled_count(cc_b)
  );

  // Outputs of whichever instance is currently under test.
  logic        rdy, tv;
  logic [47:0] tx, ty;
  logic [95:0] tz;
  logic [34:0] ar;
  logic [15:0] bx0, bx1, by0, by1, cc;
  assign rdy = sel ? rdy_b : rdy_a;
  assign tv  = sel ? tv_b  : tv_a;
  assign tx  = sel ? tx_b  : tx_a;
  assign ty  = sel ? ty_b  : ty_a;
  assign tz  = sel ? tz_b  : tz_a;
  assign ar  = sel ? ar_b  : ar_a;
  assign bx0 = sel ? bx0_b : bx0_a;
  assign bx1 = sel ? bx1_b : bx1_a;
  assign by0 = sel ? by0_b : by0_a;
  assign by1 = sel ? by1_b : by1_a;
  assign cc  = sel ? cc_b  : cc_a;

  typedef struct {
    logic signed [31:0] x0, y0, x1, y1, x2, y2;
    bit                 kept;
    logic signed [34:0] area;
    logic [15:0]        bxmin, bxmax, bymin, bymax;
  } vec_t;

  vec_t tbl [7];
  int   errors = 0;
  int   checks = 0;
  int   exp_cc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'h7FFF;
    else if (v < -32'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  function automatic logic [31:0] zword(input int r, input int v);
    return 32'hC0DE_0000 | 32'(r << 4) | 32'(v);
  endfunction

  // Entered and left at posedge+1; the word is taken on the first edge with ready high.
  task automatic push_word(input logic [31:0] w, input int gap);
    int cnt;
    fvld = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    fvld = 1'b1;
    fdat = w;
    cnt  = 0;
    while (!rdy && cnt < 100) begin @(posedge clk); #1; cnt++; end
    if (cnt >= 100) chk("push_ready_timeout", {127'd0, rdy}, 128'd1);
    @(posedge clk); #1;
    fvld = 1'b0;
  endtask

  task automatic push_range(input vec_t v, input int r, input int first, input int last, input int gap);
    logic [31:0] xs [3];
    logic [31:0] ys [3];
    logic [31:0] w;
    xs[0] = v.x0; xs[1] = v.x1; xs[2] = v.x2;
    ys[0] = v.y0; ys[1] = v.y1; ys[2] = v.y2;
    for (int k = first; k <= last; k++) begin
      case (k % 4)
        0:       w = xs[k/4];
        1:       w = ys[k/4];
        2:       w = zword(r, k/4);
        default: w = 32'h3F80_0000;
      endcase
      push_word(w, gap);
    end
  endtask

  task automatic check_tri(input vec_t v, input int r, input bit hs);
    int          n;
    logic [15:0] cc0;
    cc0 = cc;
    n   = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (tv || cc != cc0) break;
    end
    chk($sformatf("t%0d_latency", r), 128'(n), 128'd4);
    if (v.kept) begin
      chk($sformatf("t%0d_valid", r), {127'd0, tv}, 128'd1);
      chk($sformatf("t%0d_area", r), {93'd0, ar}, {93'd0, $unsigned(v.area)});
      chk($sformatf("t%0d_bxmin", r), {112'd0, bx0}, {112'd0, v.bxmin});
      chk($sformatf("t%0d_bxmax", r), {112'd0, bx1}, {112'd0, v.bxmax});
      chk($sformatf("t%0d_bymin", r), {112'd0, by0}, {112'd0, v.bymin});
      chk($sformatf("t%0d_bymax", r), {112'd0, by1}, {112'd0, v.bymax});
      chk($sformatf("t%0d_tri_x", r), {80'd0, tx}, {80'd0, sat(v.x2), sat(v.x1), sat(v.x0)});
      chk($sformatf("t%0d_tri_y", r), {80'd0, ty}, {80'd0, sat(v.y2), sat(v.y1), sat(v.y0)});
      chk($sformatf("t%0d_tri_z", r), {32'd0, tz}, {32'd0, zword(r, 2), zword(r, 1), zword(r, 0)});
      if (hs) begin
        @(posedge clk); #1;
        chk($sformatf("t%0d_hs_valid_drop", r), {127'd0, tv}, 128'd0);
        chk($sformatf("t%0d_hs_ready", r), {127'd0, rdy}, 128'd1);
      end
    end else begin
      exp_cc++;
      chk($sformatf("t%0d_cull_count", r), {112'd0, cc}, 128'(exp_cc));
      chk($sformatf("t%0d_no_valid", r), {127'd0, tv}, 128'd0);
      chk($sformatf("t%0d_ready_after_decide", r), {127'd0, rdy}, 128'd1);
    end
  endtask

  initial begin
    vec_t nb;
    //          x0           y0           x1             y1          x2          y2         kept area      bxmin bxmax bymin bymax
    tbl[0] = '{32'sd100,    32'sd100,    32'sd200,      32'sd100,   32'sd100,   32'sd200,  1'b1, 35'sd10000,  100, 200, 100, 200};
    tbl[1] = '{32'sd100,    32'sd100,    32'sd100,      32'sd200,   32'sd200,   32'sd100,  1'b0, 35'sd0,        0,   0,   0,   0};
    tbl[2] = '{32'sd0,      32'sd0,      32'sd10,       32'sd10,    32'sd20,    32'sd20,   1'b0, 35'sd0,        0,   0,   0,   0};
    tbl[3] = '{32'sd900,    32'sd0,      32'sd1000,     32'sd0,     32'sd900,   32'sd100,  1'b0, 35'sd0,        0,   0,   0,   0};
    tbl[4] = '{-32'sd50,    -32'sd50,    32'sd900,      -32'sd50,   -32'sd50,   32'sd700,  1'b1, 35'sd712500,   0, 799,   0, 599};
    tbl[5] = '{32'sd0,      32'sd0,      32'sh00100000, 32'sd0,     32'sd0,     32'sd10,   1'b1, 35'sd327670,   0, 799,   0,  10};
    tbl[6] = '{-32'sd1048576, 32'sd0,    32'sd10,       32'sd0,     32'sd10,    32'sd10,   1'b1, 35'sd327780,   0,  10,   0,  10};

    rst = 1'b1; fvld = 1'b0; fdat = '0; sel = 1'b0; tri_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {127'd0, rdy_a}, 128'd1);
    chk("rst_valid", {127'd0, tv_a}, 128'd0);
    chk("rst_area", {93'd0, ar_a}, 128'd0);
    chk("rst_tri_x", {80'd0, tx_a}, 128'd0);
    chk("rst_bbox", {64'd0, bx0_a, bx1_a, by0_a, by1_a}, 128'd0);
    chk("rst_culled", {112'd0, cc_a}, 128'd0);
    chk("rst_ready_nb", {127'd0, rdy_b}, 128'd1);
    rst = 1'b0;

    for (int r = 0; r < 7; r++) begin
      push_range(tbl[r], r, 0, 11, r % 2);
      check_tri(tbl[r], r, 1'b1);
    end

    // Back-facing triangle kept when back-face culling is disabled.
    nb = tbl[1];
    nb.kept = 1'b1; nb.area = -35'sd10000;
    nb.bxmin = 100; nb.bxmax = 200; nb.bymin = 100; nb.bymax = 200;
    sel = 1'b1;
    push_range(nb, 1, 0, 11, 0);
    check_tri(nb, 1, 1'b1);
    chk("nb_culled_zero", {112'd0, cc}, 128'd0);
    sel = 1'b0;

    // Rasterizer stall: outputs hold, no word consumed while a word is offered.
    tri_ready = 1'b0;
    push_range(tbl[0], 0, 0, 11, 0);
    check_tri(tbl[0], 0, 1'b0);
    fvld = 1'b1;
    fdat = tbl[4].x0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", c), {127'd0, tv}, 128'd1);
      chk($sformatf("stall%0d_ready", c), {127'd0, rdy}, 128'd0);
      chk($sformatf("stall%0d_area", c), {93'd0, ar}, 128'd10000);
      chk($sformatf("stall%0d_tri_x", c), {80'd0, tx}, {80'd0, 16'd100, 16'd200, 16'd100});
      chk($sformatf("stall%0d_bbox", c), {64'd0, bx0, bx1, by0, by1}, {64'd0, 16'd100, 16'd200, 16'd100, 16'd200});
    end
    tri_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid_drop", {127'd0, tv}, 128'd0);
    chk("release_ready", {127'd0, rdy}, 128'd1);
    push_range(tbl[4], 4, 0, 11, 0);
    check_tri(tbl[4], 4, 1'b1);
    chk("stall_culled_unchanged", {112'd0, cc}, 128'(exp_cc));

    // Reset after 5 words discards the partial triangle and the cull count.
    push_range(tbl[2], 2, 0, 4, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cc = 0;
    chk("midrst_ready", {127'd0, rdy}, 128'd1);
    chk("midrst_valid", {127'd0, tv}, 128'd0);
    chk("midrst_culled", {112'd0, cc}, 128'd0);
    chk("midrst_tri_x", {80'd0, tx}, 128'd0);
    chk("midrst_area", {93'd0, ar}, 128'd0);
    push_range(tbl[0], 0, 0, 11, 2);
    check_tri(tbl[0], 0, 1'b1);

    // Reset coinciding with a handshake wins; the triangle is dropped.
    tri_ready = 1'b0;
    push_range(tbl[4], 4, 0, 11, 0);
    check_tri(tbl[4], 4, 1'b0);
    tri_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_hs_valid", {127'd0, tv}, 128'd0);
    chk("rst_hs_ready", {127'd0, rdy}, 128'd1);
    chk("rst_hs_area", {93'd0, ar}, 128'd0);
    chk("rst_hs_bbox", {64'd0, bx0, bx1, by0, by1}, 128'd0);
    push_range(tbl[5], 5, 0, 11, 1);
    check_tri(tbl[5], 5, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if something wedges beyond every per-wait bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
